// File: rtl/audio_sched_if.sv
// Sample-scheduler bus: source handshakes in, serializer word and status out.
// The master modport is the driving environment; the slave modport is audio_sched.
interface audio_sched_if #(
    parameter int unsigned DW     = 16,
    parameter int unsigned UCNT_W = 8
) ();
    logic              enable;
    logic              frame_req;
    logic              src0_valid;
    logic [DW-1:0]     src0_data;
    logic              src0_ready;
    logic              src1_valid;
    logic [DW-1:0]     src1_data;
    logic              src1_ready;
    logic [DW-1:0]     smp_out;
    logic              smp_load;
    logic              underrun;
    logic [UCNT_W-1:0] ucnt;
    logic              missed;

    modport master (
        output enable, frame_req, src0_valid, src0_data, src1_valid, src1_data,
        input  src0_ready, src1_ready, smp_out, smp_load, underrun, ucnt, missed
    );

    modport slave (
        input  enable, frame_req, src0_valid, src0_data, src1_valid, src1_data,
        output src0_ready, src1_ready, smp_out, smp_load, underrun, ucnt, missed
    );
endinterface

// File: rtl/audio_sched.sv
// Per-slot sample scheduler for the PCM/I2S serializer: WAIT -> ARB -> LOAD.
// Define AUDIO_SCHED_MIX_EN to sum both sources (saturating) instead of arbitrating.
module audio_sched #(
    parameter int unsigned DW         = 16,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned UCNT_W     = 8
) (
    input logic          clk,
    input logic          reset,
    audio_sched_if.slave bus
);
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StWait, StArb, StLoad} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [DW-1:0]     smp_out_q, smp_out_d;
    logic              smp_load_q, smp_load_d;
    logic              underrun_q, underrun_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;
    logic              missed_q, missed_d;

    logic              arb_en;
    logic              grant0, grant1;
    logic [DW-1:0]     word;

    assign arb_en = (state_q == StArb) && bus.enable;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (arb_en) begin
`ifdef AUDIO_SCHED_MIX_EN
            grant0 = bus.src0_valid;
            grant1 = bus.src1_valid;
`else
            if (bus.src0_valid && bus.src1_valid) begin
                // src1 wins only once src0 has held it off STARVE_MAX times in a row
                if (starve_q == SW'(STARVE_MAX)) grant1 = 1'b1;
                else                             grant0 = 1'b1;
            end else begin
                grant0 = bus.src0_valid;
                grant1 = bus.src1_valid;
            end
`endif
        end
    end

`ifdef AUDIO_SCHED_MIX_EN
    logic [DW-1:0] op0, op1;
    logic [DW:0]   mix_sum;

    always_comb begin
        op0     = grant0 ? bus.src0_data : '0;
        op1     = grant1 ? bus.src1_data : '0;
        mix_sum = {op0[DW-1], op0} + {op1[DW-1], op1};
        // Top two bits disagree only on signed overflow; clamp toward the sign of the sum.
        if (mix_sum[DW] != mix_sum[DW-1]) begin
            word = mix_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            word = mix_sum[DW-1:0];
        end
    end
`else
    always_comb begin
        word = '0;
        if (grant1)      word = bus.src1_data;
        else if (grant0) word = bus.src0_data;
    end
`endif

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        smp_out_d  = smp_out_q;
        smp_load_d = 1'b0;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        missed_d   = bus.frame_req && (state_q != StWait);

        unique case (state_q)
            StWait: if (bus.frame_req) state_d = StArb;
            StArb: begin
                state_d    = StLoad;
                smp_load_d = 1'b1;
                smp_out_d  = word;
                underrun_d = arb_en && !bus.src0_valid && !bus.src1_valid;
                if (underrun_d && (ucnt_q != '1)) ucnt_d = ucnt_q + UCNT_W'(1);
`ifdef AUDIO_SCHED_MIX_EN
                starve_d = '0;
`else
                if (grant1 || !bus.src1_valid) begin
                    starve_d = '0;
                end else if (grant0 && (starve_q < SW'(STARVE_MAX))) begin
                    starve_d = starve_q + SW'(1);
                end
`endif
            end
            StLoad:  state_d = StWait;
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StWait;
            starve_q   <= '0;
            smp_out_q  <= '0;
            smp_load_q <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            smp_out_q  <= smp_out_d;
            smp_load_q <= smp_load_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
            missed_q   <= missed_d;
        end
    end

    assign bus.src0_ready = grant0;
    assign bus.src1_ready = grant1;
    assign bus.smp_out    = smp_out_q;
    assign bus.smp_load   = smp_load_q;
    assign bus.underrun   = underrun_q;
    assign bus.ucnt       = ucnt_q;
    assign bus.missed     = missed_q;
endmodule

// File: tb/tb_audio_sched.sv
// Self-checking bench for audio_sched: vector table, grant order, underrun saturation,
// missed frames, and reset abort; expected load words flow through a scoreboard queue.
module tb_audio_sched;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    audio_sched_if #(.DW(16), .UCNT_W(8)) bus ();

    audio_sched #(.DW(16), .STARVE_MAX(4), .UCNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [15:0] w;
        logic        u;
        logic [7:0]  c;
    } exp_t;

    typedef struct {
        logic        en, v0, v1;
        logic [15:0] d0, d1;
        logic        r0, r1;
        logic [15:0] w;
        logic        u;
    } vec_t;

    exp_t     sbq[$];
    int       n_vec  = 0;
    int       n_fail = 0;
    logic [7:0] ucnt_m = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic slot(input logic en, input logic v0, input logic v1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic er0, input logic er1,
                        input logic [15:0] ew, input logic eu);
        exp_t e;
        logic got;
        bus.enable     = en;
        bus.src0_valid = v0;
        bus.src1_valid = v1;
        bus.src0_data  = d0;
        bus.src1_data  = d1;
        bus.frame_req  = 1'b1;
        @(posedge clk); #1;
        bus.frame_req = 1'b0;
        check("src0_ready", bus.src0_ready, er0);
        check("src1_ready", bus.src1_ready, er1);
        check("load_early", bus.smp_load, 1'b0);
        if (eu && ucnt_m != 8'hFF) ucnt_m = ucnt_m + 8'h01;
        sbq.push_back('{w: ew, u: eu, c: ucnt_m});
        got = 1'b0;
        for (int k = 0; k < 3 && !got; k++) begin
            @(posedge clk); #1;
            if (bus.smp_load) got = 1'b1;
        end
        check("load_seen", got, 1'b1);
        if (got && sbq.size() > 0) begin
            e = sbq.pop_front();
            check("smp_out", bus.smp_out, e.w);
            check("underrun", bus.underrun, e.u);
            check("ucnt", bus.ucnt, e.c);
            check("missed_idle", bus.missed, 1'b0);
        end
        bus.src0_valid = 1'b0;
        bus.src1_valid = 1'b0;
        @(posedge clk); #1;
        check("load_pulse", bus.smp_load, 1'b0);
    endtask

    vec_t vecs[7];
    logic order[10];

    initial begin
        bus.enable = 1'b0; bus.frame_req = 1'b0;
        bus.src0_valid = 1'b0; bus.src1_valid = 1'b0;
        bus.src0_data = '0; bus.src1_data = '0;

        vecs[0] = '{1, 1, 0, 16'h1234, 16'h0000, 1, 0, 16'h1234, 0};
        vecs[1] = '{1, 0, 1, 16'h0000, 16'hABCD, 0, 1, 16'hABCD, 0};
`ifdef AUDIO_SCHED_MIX_EN
        vecs[2] = '{1, 1, 1, 16'h8001, 16'h7FFE, 1, 1, 16'hFFFF, 0};
`else
        vecs[2] = '{1, 1, 1, 16'h8001, 16'h7FFE, 1, 0, 16'h8001, 0};
`endif
        vecs[3] = '{1, 0, 0, 16'h5555, 16'hAAAA, 0, 0, 16'h0000, 1};
        vecs[4] = '{0, 1, 1, 16'h1111, 16'h2222, 0, 0, 16'h0000, 0};
        vecs[5] = '{0, 0, 0, 16'h3333, 16'h4444, 0, 0, 16'h0000, 0};
        vecs[6] = '{1, 1, 0, 16'hFFFF, 16'h0000, 1, 0, 16'hFFFF, 0};
        order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_load", bus.smp_load, 1'b0);
        check("rst_out", bus.smp_out, 16'h0000);
        check("rst_ucnt", bus.ucnt, 8'h00);
        check("rst_missed", bus.missed, 1'b0);
        check("rst_under", bus.underrun, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            slot(vecs[i].en, vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1,
                 vecs[i].r0, vecs[i].r1, vecs[i].w, vecs[i].u);
        end

        // Both sources always valid: grant order from a cleared starvation count
        for (int i = 0; i < 10; i++) begin
            logic [15:0] a, b;
            a = 16'(16'h1000 + i);
            b = 16'(16'h2000 + i);
`ifdef AUDIO_SCHED_MIX_EN
            slot(1, 1, 1, a, b, 1, 1, 16'(a + b), 0);
`else
            slot(1, 1, 1, a, b, !order[i], order[i], order[i] ? b : a, 0);
`endif
        end

        // Underruns saturate the counter
        for (int i = 0; i < 300; i++) slot(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1);
        check("ucnt_sat", bus.ucnt, 8'hFF);

        // frame_req on two consecutive cycles: second is missed, single load
        bus.enable = 1'b1; bus.src0_valid = 1'b1; bus.src0_data = 16'h0F0F;
        bus.frame_req = 1'b1;
        @(posedge clk); #1;
        check("dbl_ready", bus.src0_ready, 1'b1);
        @(posedge clk); #1;
        bus.frame_req = 1'b0;
        bus.src0_valid = 1'b0;
        check("dbl_load", bus.smp_load, 1'b1);
        check("dbl_word", bus.smp_out, 16'h0F0F);
        check("dbl_missed", bus.missed, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("dbl_noload", bus.smp_load, 1'b0);
            check("dbl_miss_clr", bus.missed, 1'b0);
        end

        // Reset in the ARB cycle aborts the slot and clears the counter
        bus.src0_valid = 1'b1; bus.src0_data = 16'h7777; bus.frame_req = 1'b1;
        @(posedge clk); #1;
        bus.frame_req = 1'b0;
        check("abort_ready_pre", bus.src0_ready, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_ready", bus.src0_ready, 1'b0);
        check("abort_ucnt", bus.ucnt, 8'h00);
        ucnt_m = 8'h00;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort_noload", bus.smp_load, 1'b0);
            check("abort_noready", bus.src0_ready, 1'b0);
        end
        slot(1, 1, 0, 16'h7777, 16'h0000, 1, 0, 16'h7777, 0);

`ifdef AUDIO_SCHED_MIX_EN
        slot(1, 1, 1, 16'h7000, 16'h2000, 1, 1, 16'h7FFF, 0);
        slot(1, 1, 1, 16'h8000, 16'hF000, 1, 1, 16'h8000, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
